regfile_mp: RTL and testbench

Parametrised multi-port register file for the next-generation RV32 core datapath. It has NRD registered read ports and NWR write ports, with write-to-read bypass, a hardwired zero register, and a pending-write scoreboard for pipeline hazard detection. After reset, a clear sequencer initialises the storage one entry per cycle while `busy` is high. It sits between decode (reads, issue) and writeback (writes), and replaces the single-write, unregistered-read file of the earlier core.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_scoreboard.sv | 50 +++++
 rtl/regfile_mp.sv | 121 ++++++++++++
 tb/tb_regfile_mp.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizing helpers for the multi-port register file.
package regfile_pkg;

  localparam int DEFAULT_XLEN  = 32;
  localparam int DEFAULT_NREGS = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic int calc_aw(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
// Lookups return the post-update view so decode sees this cycle's issue/writeback.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = DEFAULT_NREGS,
  parameter int NRD   = 2,
  parameter int NWR   = 1,
  localparam int AW   = calc_aw(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set_en,
  input  logic [AW-1:0]     set_addr,
  input  logic [NWR-1:0]    clr_en,
  input  logic [NWR*AW-1:0] clr_addr,
  input  logic [NRD*AW-1:0] look_addr,
  output logic [NRD-1:0]    look_pending
);

  logic [NREGS-1:0] pending_reg;
  logic [NREGS-1:0] pending_next;

  // Set is applied after clears so a new producer outranks a retiring one.
  always_comb begin
    pending_next = pending_reg;
    for (int p = 0; p < NWR; p++) begin
      if (clr_en[p]) begin
        pending_next[clr_addr[p*AW +: AW]] = 1'b0;
      end
    end
    if (set_en) begin
      pending_next[set_addr] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_look
    assign look_pending[gi] = pending_next[look_addr[gi*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-first bypass, hardwired x0,
// pending-write scoreboard and a post-reset clear sequencer.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int              XLEN        = DEFAULT_XLEN,
  parameter int              NREGS       = DEFAULT_NREGS,
  parameter int              NRD         = 2,
  parameter int              NWR         = 1,
  parameter logic [XLEN-1:0] RESET_VALUE = '0,
  localparam int             AW          = calc_aw(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_pending,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  output logic                busy
);

  state_t               state_reg;
  logic [AW-1:0]        idx_reg;
  logic [XLEN-1:0]      mem [NREGS];
  logic [NRD*XLEN-1:0]  rd_data_reg;
  logic [NRD*XLEN-1:0]  rd_data_next;
  logic [NRD-1:0]       rd_pending_reg;
  logic [NRD-1:0]       look_pending;
  logic                 run;
  logic [NWR-1:0]       wr_en_run;
  logic                 iss_set;

  assign run       = (state_reg == RUN);
  assign wr_en_run = run ? wr_en : '0;
  assign iss_set   = run && iss_valid && (iss_addr != '0);
  assign busy      = ~run;

  // Clear sequencer: walks idx 1..NREGS-1, then hands over to RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= CLEAR;
      idx_reg   <= AW'(1);
    end else if (state_reg == CLEAR) begin
      idx_reg <= idx_reg + AW'(1);
      if (idx_reg == AW'(NREGS - 1)) begin
        state_reg <= RUN;
      end
    end
  end

  // Ascending port order makes the highest-index port the last (winning) write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_reg == CLEAR) begin
        mem[idx_reg] <= RESET_VALUE;
      end else begin
        for (int p = 0; p < NWR; p++) begin
          if (wr_en[p] && (wr_addr[p*AW +: AW] != '0)) begin
            mem[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];
          end
        end
      end
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic            byp_hit;
    logic [XLEN-1:0] byp_data;

    assign addr = rd_addr[gi*AW +: AW];

    always_comb begin
      byp_hit  = 1'b0;
      byp_data = '0;
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && (wr_addr[p*AW +: AW] == addr)) begin
          byp_hit  = 1'b1;
          byp_data = wr_data[p*XLEN +: XLEN];
        end
      end
    end

    assign rd_data_next[gi*XLEN +: XLEN] = (addr == '0) ? '0 :
                                           byp_hit      ? byp_data :
                                                          mem[addr];
  end

  always_ff @(posedge clk) begin
    if (reset || (state_reg == CLEAR)) begin
      rd_data_reg    <= '0;
      rd_pending_reg <= '0;
    end else begin
      rd_data_reg    <= rd_data_next;
      rd_pending_reg <= look_pending;
    end
  end

  assign rd_data    = rd_data_reg;
  assign rd_pending = rd_pending_reg;

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .set_en       (iss_set),
    .set_addr     (iss_addr),
    .clr_en       (wr_en_run),
    .clr_addr     (wr_addr),
    .look_addr    (rd_addr),
    .look_pending (look_pending)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// against an array-based reference model.
module tb_regfile_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;
  localparam logic [XLEN-1:0] RV = 32'hA5A5A5A5;

  logic                clk = 1'b0;
  logic                reset;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_pending;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic                busy;

  int checks   = 0;
  int failures = 0;

  logic [XLEN-1:0] model_regs [NREGS];
  logic            model_pend [NREGS];
  logic [XLEN-1:0] exp_data   [NRD];
  logic            exp_pend   [NRD];

  always #5 clk = ~clk;

  regfile_mp #(
    .XLEN        (XLEN),
    .NREGS       (NREGS),
    .NRD         (NRD),
    .NWR         (NWR),
    .RESET_VALUE (RV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_pending (rd_pending),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .iss_valid  (iss_valid),
    .iss_addr   (iss_addr),
    .busy       (busy)
  );

  task automatic idle();
    wr_en     = '0;
    wr_addr   = '0;
    wr_data   = '0;
    iss_valid = 1'b0;
    iss_addr  = '0;
  endtask

  task automatic set_wr(input int p, input int a, input logic [XLEN-1:0] d);
    wr_en[p]             = 1'b1;
    wr_addr[p*AW +: AW]  = AW'(a);
    wr_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic set_rd(input int k, input int a);
    rd_addr[k*AW +: AW] = AW'(a);
  endtask

  task automatic model_clear();
    for (int i = 0; i < NREGS; i++) begin
      model_regs[i] = (i == 0) ? '0 : RV;
      model_pend[i] = 1'b0;
    end
  endtask

  // Predict this cycle's read results, advance one clock, then retire writes/issues.
  task automatic step();
    for (int k = 0; k < NRD; k++) begin
      int a;
      logic [XLEN-1:0] d;
      logic pd;
      a  = int'(rd_addr[k*AW +: AW]);
      d  = model_regs[a];
      pd = model_pend[a];
      for (int p = 0; p < NWR; p++) begin
        if (wr_en[p] && int'(wr_addr[p*AW +: AW]) == a) begin
          d  = wr_data[p*XLEN +: XLEN];
          pd = 1'b0;
        end
      end
      if (iss_valid && int'(iss_addr) == a) pd = 1'b1;
      if (a == 0) begin
        d  = '0;
        pd = 1'b0;
      end
      exp_data[k] = d;
      exp_pend[k] = pd;
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < NWR; p++) begin
      int a;
      a = int'(wr_addr[p*AW +: AW]);
      if (wr_en[p] && a != 0) model_regs[a] = wr_data[p*XLEN +: XLEN];
      if (wr_en[p]) model_pend[a] = 1'b0;
    end
    if (iss_valid && iss_addr != '0) model_pend[int'(iss_addr)] = 1'b1;
  endtask

  task automatic wait_clear(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      rd_addr   = NRD*AW'($urandom);
      wr_en     = NWR'($urandom);
      wr_addr   = NWR*AW'($urandom);
      wr_data   = {$urandom, $urandom};
      iss_valid = 1'b1;
      iss_addr  = AW'($urandom);
      checks++;
      if (rd_data !== '0 || rd_pending !== '0) begin
        failures++;
        $display("FAIL %s_outputs_in_clear got data=%h pend=%b want zero", name, rd_data, rd_pending);
      end
      n++;
      @(posedge clk);
      #1;
    end
    idle();
    checks++;
    if (n !== 31) begin
      failures++;
      $display("FAIL %s_busy_cycles got=%0d want=31", name, n);
    end
    model_clear();
  endtask

  task automatic test_reset();
    idle();
    rd_addr = '0;
    reset   = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_rd(0, $urandom_range(1, 31));
      @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1 || rd_data !== '0 || rd_pending !== '0) begin
        failures++;
        $display("FAIL reset_state got busy=%b data=%h pend=%b want busy=1 data=0 pend=0",
                 busy, rd_data, rd_pending);
      end
    end
    reset = 1'b0;
    wait_clear("reset");
  endtask

  task automatic test_clear_values();
    idle();
    set_rd(0, 7);
    set_rd(1, 0);
    step();
    checks++;
    if (rd_data[0 +: XLEN] !== RV || rd_pending[0] !== 1'b0) begin
      failures++;
      $display("FAIL clear_x7 got=%h/%b want=%h/0", rd_data[0 +: XLEN], rd_pending[0], RV);
    end
    checks++;
    if (rd_data[XLEN +: XLEN] !== '0) begin
      failures++;
      $display("FAIL clear_x0 got=%h want=0", rd_data[XLEN +: XLEN]);
    end
  endtask

  task automatic test_bypass();
    idle();
    set_wr(0, 5, 32'h12345678);
    set_rd(0, 5);
    set_rd(1, 7);
    step();
    checks++;
    if (rd_data[0 +: XLEN] !== 32'h12345678) begin
      failures++;
      $display("FAIL bypass_same_cycle got=%h want=12345678", rd_data[0 +: XLEN]);
    end
    idle();
    set_rd(0, 1);
    step();
    set_rd(0, 5);
    step();
    checks++;
    if (rd_data[0 +: XLEN] !== 32'h12345678) begin
      failures++;
      $display("FAIL bypass_storage got=%h want=12345678", rd_data[0 +: XLEN]);
    end
  endtask

  task automatic test_collision();
    idle();
    set_wr(0, 9, 32'd1);
    set_wr(1, 9, 32'd2);
    set_rd(0, 9);
    set_rd(1, 9);
    step();
    for (int k = 0; k < NRD; k++) begin
      checks++;
      if (rd_data[k*XLEN +: XLEN] !== 32'd2) begin
        failures++;
        $display("FAIL collision_bypass port=%0d got=%h want=2", k, rd_data[k*XLEN +: XLEN]);
      end
    end
    idle();
    step();
    checks++;
    if (rd_data[XLEN +: XLEN] !== 32'd2) begin
      failures++;
      $display("FAIL collision_storage got=%h want=2", rd_data[XLEN +: XLEN]);
    end
  endtask

  task automatic test_x0();
    idle();
    set_wr(0, 0, 32'hFFFFFFFF);
    set_wr(1, 0, 32'hFFFFFFFF);
    iss_valid = 1'b1;
    iss_addr  = '0;
    set_rd(0, 0);
    set_rd(1, 0);
    step();
    checks++;
    if (rd_data !== '0 || rd_pending !== '0) begin
      failures++;
      $display("FAIL x0_same_cycle got data=%h pend=%b want 0/0", rd_data, rd_pending);
    end
    idle();
    step();
    checks++;
    if (rd_data !== '0 || rd_pending !== '0) begin
      failures++;
      $display("FAIL x0_after got data=%h pend=%b want 0/0", rd_data, rd_pending);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    set_rd(0, 3);
    set_rd(1, 4);
    iss_valid = 1'b1;
    iss_addr  = AW'(3);
    step();
    checks++;
    if (rd_pending[0] !== 1'b1) begin
      failures++;
      $display("FAIL sb_issue got=%b want=1", rd_pending[0]);
    end
    set_wr(1, 3, 32'hCAFE0003);
    step();
    checks++;
    if (rd_pending[0] !== 1'b1 || rd_data[0 +: XLEN] !== 32'hCAFE0003) begin
      failures++;
      $display("FAIL sb_set_wins got=%b/%h want=1/cafe0003", rd_pending[0], rd_data[0 +: XLEN]);
    end
    idle();
    step();
    checks++;
    if (rd_pending[0] !== 1'b1) begin
      failures++;
      $display("FAIL sb_hold got=%b want=1", rd_pending[0]);
    end
    set_wr(0, 3, 32'h00000033);
    step();
    checks++;
    if (rd_pending[0] !== 1'b0) begin
      failures++;
      $display("FAIL sb_clear got=%b want=0", rd_pending[0]);
    end
    idle();
    step();
    checks++;
    if (rd_pending[0] !== 1'b0 || rd_data[0 +: XLEN] !== 32'h00000033) begin
      failures++;
      $display("FAIL sb_after_clear got=%b/%h want=0/00000033", rd_pending[0], rd_data[0 +: XLEN]);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < NRD; k++) begin
        set_rd(k, ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 31));
      end
      for (int p = 0; p < NWR; p++) begin
        wr_en[p] = ($urandom_range(0, 2) == 0);
        wr_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
        wr_data[p*XLEN +: XLEN] = $urandom;
      end
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_addr  = AW'($urandom_range(0, 7));
      step();
      for (int k = 0; k < NRD; k++) begin
        checks++;
        if (rd_data[k*XLEN +: XLEN] !== exp_data[k] || rd_pending[k] !== exp_pend[k]) begin
          failures++;
          $display("FAIL random c=%0d port=%0d got=%h/%b want=%h/%b", c, k,
                   rd_data[k*XLEN +: XLEN], rd_pending[k], exp_data[k], exp_pend[k]);
        end
      end
    end
    idle();
  endtask

  task automatic test_mid_reset();
    idle();
    set_wr(0, 4, 32'h55);
    iss_valid = 1'b1;
    iss_addr  = AW'(6);
    step();
    idle();
    set_rd(0, 4);
    set_rd(1, 6);
    step();
    checks++;
    if (rd_data[0 +: XLEN] !== 32'h55 || rd_pending[1] !== 1'b1) begin
      failures++;
      $display("FAIL midreset_before got=%h/%b want=00000055/1", rd_data[0 +: XLEN], rd_pending[1]);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_busy_rise got=%b want=1", busy);
    end
    wait_clear("midreset");
    set_rd(0, 4);
    set_rd(1, 6);
    step();
    checks++;
    if (rd_data[0 +: XLEN] !== RV || rd_pending !== '0) begin
      failures++;
      $display("FAIL midreset_after got=%h/%b want=%h/00", rd_data[0 +: XLEN], rd_pending, RV);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    rd_addr = '0;
    idle();
    test_reset();
    test_clear_values();
    test_bypass();
    test_collision();
    test_x0();
    test_scoreboard();
    test_random();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
